// File: rtl/opc5_mem_arbiter_if.sv
// Bus bundle between the two masters (OPC5 CPU on port 0, DMA/loader on
// port 1), the arbiter and the shared single-port memory.
//   slave  : arbiter side
//   master : system side (both bus masters plus the memory array)
interface opc5_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              p0_req;
    logic              p0_rnw;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;

    logic              p1_req;
    logic              p1_rnw;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ce_b;
    logic              mem_we_b;

    modport slave (
        input  p0_req, p0_rnw, p0_addr, p0_wdata,
        input  p1_req, p1_rnw, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p1_ack, rdata, busy,
        output mem_addr, mem_wdata, mem_ce_b, mem_we_b
    );

    modport master (
        output p0_req, p0_rnw, p0_addr, p0_wdata,
        output p1_req, p1_rnw, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p1_ack, rdata, busy,
        input  mem_addr, mem_wdata, mem_ce_b, mem_we_b
    );
endinterface

// File: rtl/opc5_mem_arbiter.sv
// Two-port arbiter for one shared single-port memory.
// One access at a time, WAIT_STATES extra ACCESS cycles, active-low strobes.
// Build option OPC5_ARB_FIXED_PRIO_EN: port 0 always wins simultaneous
// requests (no last_grant state); otherwise round robin.
//
//   state  | meaning
//   IDLE   | no access in flight; sample requests and grant one
//   ACCESS | ce_b low (we_b low on writes); wait counter runs down to 0
//   DONE   | strobes released; ack pulses for the granted port, rdata valid
module opc5_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    opc5_mem_arbiter_if.slave      bus
);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic                r_grant,     w_grant_nxt;
    logic                r_rnw,       w_rnw_nxt;
    logic [3:0]          r_cnt,       w_cnt_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_rdata,     w_rdata_nxt;
    logic                r_p0_ack,    w_p0_ack_nxt;
    logic                r_p1_ack,    w_p1_ack_nxt;
    logic                r_ce_b,      w_ce_b_nxt;
    logic                r_we_b,      w_we_b_nxt;
    logic                r_busy,      w_busy_nxt;

    logic                w_any_req;
    logic                w_win;

    assign w_any_req = bus.p0_req | bus.p1_req;

`ifdef OPC5_ARB_FIXED_PRIO_EN
    // Port 1 only wins when the CPU is not asking.
    assign w_win = ~bus.p0_req;
`else
    logic r_last_grant;

    // Contention goes to the port not served last; a lone requester always wins.
    assign w_win = (bus.p0_req & bus.p1_req) ? ~r_last_grant : bus.p1_req;

    // Remember who was granted most recently (1 after reset so port 0 goes first).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant <= w_win;
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below so the
    // strobes always line up with the state they belong to.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rnw_nxt       = r_rnw;
        w_cnt_nxt       = r_cnt;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rdata_nxt     = r_rdata;
        w_p0_ack_nxt    = 1'b0;
        w_p1_ack_nxt    = 1'b0;
        w_ce_b_nxt      = 1'b1;
        w_we_b_nxt      = 1'b1;
        w_busy_nxt      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_any_req) begin
                    w_state_nxt     = S_ACCESS;
                    w_grant_nxt     = w_win;
                    w_rnw_nxt       = w_win ? bus.p1_rnw   : bus.p0_rnw;
                    w_mem_addr_nxt  = w_win ? bus.p1_addr  : bus.p0_addr;
                    w_mem_wdata_nxt = w_win ? bus.p1_wdata : bus.p0_wdata;
                    w_cnt_nxt       = LP_WAIT;
                    w_ce_b_nxt      = 1'b0;
                    w_we_b_nxt      = w_win ? bus.p1_rnw : bus.p0_rnw;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt  = r_cnt - 4'd1;
                    w_ce_b_nxt = 1'b0;
                    w_we_b_nxt = r_rnw;
                end else begin
                    // Writes leave rdata holding the last read value.
                    if (r_rnw) begin
                        w_rdata_nxt = bus.mem_rdata;
                    end
                    w_state_nxt  = S_DONE;
                    w_p0_ack_nxt = ~r_grant;
                    w_p1_ack_nxt = r_grant;
                end
            end
            S_DONE: begin
                // Always pass through IDLE so a still-high req is not re-granted here.
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases the strobes without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= 1'b0;
            r_rnw       <= 1'b1;
            r_cnt       <= 4'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_p0_ack    <= 1'b0;
            r_p1_ack    <= 1'b0;
            r_ce_b      <= 1'b1;
            r_we_b      <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rnw       <= w_rnw_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_p0_ack    <= w_p0_ack_nxt;
            r_p1_ack    <= w_p1_ack_nxt;
            r_ce_b      <= w_ce_b_nxt;
            r_we_b      <= w_we_b_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.p0_ack    = r_p0_ack;
    assign bus.p1_ack    = r_p1_ack;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_ce_b  = r_ce_b;
    assign bus.mem_we_b  = r_we_b;
endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// Bench for opc5_mem_arbiter: directed scenarios plus randomized two-master
// traffic, checked every cycle against a transaction-level timing model.
// Honours OPC5_ARB_FIXED_PRIO_EN the same way as the design.
module tb_opc5_mem_arbiter;
    localparam int TB_WS = 3;
`ifdef OPC5_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial forever #5 clk = ~clk;

    opc5_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    opc5_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(TB_WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- memory array ----------------
    logic [15:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];

    function automatic logic [15:0] init_val(input int a);
        logic [15:0] v;
        v = 16'(a);
        return (v == 16'h0010) ? 16'hBEEF : ({v[7:0], v[7:0]} ^ 16'h3C5A);
    endfunction

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = init_val(a);
        forever begin
            @(negedge clk);
            if (bus.mem_ce_b === 1'b0 && bus.mem_we_b === 1'b0) mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A granted transfer at edge s occupies the memory for edges s..s+WS
    // (ACCESS), completes at edge s+WS+1 (DONE/ack) and the next grant can
    // happen no earlier than edge s+WS+3.
    logic [15:0] shadow [0:65535];
    bit          m_act, m_port, m_rnw, m_last, m_win;
    int          m_start, m_free;
    logic [15:0] m_addr, m_wdata, e_addr, e_wdata, e_rdata;

    initial begin
        for (int a = 0; a < 65536; a++) shadow[a] = init_val(a);
        m_act = 0; m_last = 1; m_free = 0; m_start = 0; m_port = 0; m_rnw = 1;
        m_addr = '0; m_wdata = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_act = 0; m_last = 1; m_free = 0;
                e_addr = '0; e_wdata = '0; e_rdata = '0;
            end else begin
                cyc++;
                if (m_act && cyc == m_start + TB_WS + 1) begin
                    if (m_rnw) e_rdata = shadow[m_addr];
                    else       shadow[m_addr] = m_wdata;
                end
                if (cyc >= m_free && (bus.p0_req || bus.p1_req)) begin
                    if (bus.p0_req && bus.p1_req) m_win = FIXED ? 1'b0 : !m_last;
                    else                          m_win = bus.p1_req;
                    m_last  = m_win;
                    m_act   = 1;
                    m_start = cyc;
                    m_port  = m_win;
                    m_rnw   = m_win ? bus.p1_rnw   : bus.p0_rnw;
                    m_addr  = m_win ? bus.p1_addr  : bus.p0_addr;
                    m_wdata = m_win ? bus.p1_wdata : bus.p0_wdata;
                    e_addr  = m_addr;
                    e_wdata = m_wdata;
                    m_free  = cyc + TB_WS + 3;
                end
            end
        end
    end

    // ---------------- per-cycle compare + activity counters ----------------
    int ce_low_cnt = 0, we_low_cnt = 0, p0_ack_cnt = 0, p1_ack_cnt = 0, busy_low_cnt = 0;
    bit e_acc, e_done;

    initial begin
        forever begin
            @(negedge clk);
            e_acc  = m_act && (cyc >= m_start) && (cyc <= m_start + TB_WS);
            e_done = m_act && (cyc == m_start + TB_WS + 1);
            chk("busy",      32'(bus.busy),      32'(e_acc || e_done));
            chk("mem_ce_b",  32'(bus.mem_ce_b),  32'(!e_acc));
            chk("mem_we_b",  32'(bus.mem_we_b),  32'(!(e_acc && !m_rnw)));
            chk("p0_ack",    32'(bus.p0_ack),    32'(e_done && !m_port));
            chk("p1_ack",    32'(bus.p1_ack),    32'(e_done && m_port));
            chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
            chk("rdata",     32'(bus.rdata),     32'(e_rdata));
            if (bus.mem_ce_b === 1'b0) ce_low_cnt++;
            if (bus.mem_we_b === 1'b0) we_low_cnt++;
            if (bus.p0_ack === 1'b1)   p0_ack_cnt++;
            if (bus.p1_ack === 1'b1)   p1_ack_cnt++;
            if (bus.busy === 1'b0)     busy_low_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- master driver ----------------
    task automatic xfer(input bit p, input bit rnw, input logic [15:0] a, input logic [15:0] d,
                        input bit hold, output int req_cyc, output int ack_cyc, output logic [15:0] rd);
        bit got;
        got = 0; ack_cyc = -1; rd = '0;
        @(posedge clk); #2;
        req_cyc = cyc;
        if (!p) begin bus.p0_req = 1; bus.p0_rnw = rnw; bus.p0_addr = a; bus.p0_wdata = d; end
        else    begin bus.p1_req = 1; bus.p1_rnw = rnw; bus.p1_addr = a; bus.p1_wdata = d; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((p ? bus.p1_ack : bus.p0_ack) === 1'b1) begin
                got = 1; ack_cyc = cyc; rd = bus.rdata;
            end
        end
        if (!got) chk(p ? "p1_ack_timeout" : "p0_ack_timeout", 32'(got), 32'd1);
        if (!hold) begin
            @(posedge clk); #2;
            if (!p) bus.p0_req = 0; else bus.p1_req = 0;
        end
    endtask

    task automatic clear_counts();
        ce_low_cnt = 0; we_low_cnt = 0; p0_ack_cnt = 0; p1_ack_cnt = 0; busy_low_cnt = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
    endtask

    int rc, ac, a0, p1c, b0c, dummy;
    int acks [4];
    logic [15:0] rd, rd_b;

    initial begin
        reset = 1;
        bus.p0_req = 0; bus.p0_rnw = 1; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_rnw = 1; bus.p1_addr = '0; bus.p1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata",    32'(bus.rdata),    32'd0);
        chk("rst_ce_b",     32'(bus.mem_ce_b), 32'd1);
        chk("rst_we_b",     32'(bus.mem_we_b), 32'd1);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        @(posedge clk); #2;
        reset = 0;

        // single read: ack WS+2 cycles after the drive cycle, ce_b low WS+1 cycles
        clear_counts();
        xfer(0, 1, 16'h0010, 16'h0000, 0, rc, ac, rd);
        chk("t1_rdata",   32'(rd),         32'h0000BEEF);
        chk("t1_latency", 32'(ac - rc),    32'd5);
        chk("t1_ce_low",  32'(ce_low_cnt), 32'd4);
        repeat (2) @(posedge clk);
        chk("t1_p0_acks", 32'(p0_ack_cnt), 32'd1);
        chk("t1_p1_acks", 32'(p1_ack_cnt), 32'd0);

        // single write on port 1: we_b low exactly 4 cycles, rdata untouched
        clear_counts();
        xfer(1, 0, 16'h00FF, 16'h1234, 0, rc, ac, rd);
        chk("t2_we_low",  32'(we_low_cnt),  32'd4);
        chk("t2_mem",     32'(mem[16'h00FF]), 32'h00001234);
        chk("t2_rdata",   32'(bus.rdata),   32'h0000BEEF);
        chk("t2_p1_acks", 32'(p1_ack_cnt),  32'd1);
        chk("t2_p0_acks", 32'(p0_ack_cnt),  32'd0);

        // contention right after reset; p0 re-requests straight after its first ack
        pulse_reset();
        fork
            begin
                xfer(0, 1, 16'h0001, 16'h0000, 1, dummy, a0, rd);
                xfer(0, 1, 16'h0002, 16'h0000, 0, dummy, b0c, rd_b);
            end
            xfer(1, 0, 16'h0002, 16'hA5A5, 0, dummy, p1c, rd);
        join
        chk("t3_p0_first",  32'(a0 < p1c && a0 < b0c), 32'd1);
        if (FIXED) begin
            chk("t3_fixed_p0_again", 32'(b0c < p1c), 32'd1);
            chk("t3_fixed_rd",       32'(rd_b),      32'h00003E58);
        end else begin
            chk("t3_rr_p1_second", 32'(p1c < b0c),  32'd1);
            chk("t3_rr_gap",       32'(p1c - a0),   32'd6);
            chk("t3_rr_rd",        32'(rd_b),       32'h0000A5A5);
        end

        // back-to-back reads with req held: acks WS+3 apart, one idle cycle between
        xfer(0, 1, 16'h0000, 16'h0000, 1, dummy, acks[0], rd);
        busy_low_cnt = 0;
        for (int i = 1; i < 4; i++) xfer(0, 1, 16'(i), 16'h0000, i < 3, dummy, acks[i], rd);
        for (int i = 1; i < 4; i++) chk("t4_ack_spacing", 32'(acks[i] - acks[i-1]), 32'd6);
        chk("t4_busy_low", 32'(busy_low_cnt), 32'd3);

        // reset during the third ACCESS cycle of a long write
        clear_counts();
        @(posedge clk); #2;
        bus.p1_req = 1; bus.p1_rnw = 0; bus.p1_addr = 16'h0300; bus.p1_wdata = 16'hDEAD;
        repeat (3) @(posedge clk);
        #3;
        chk("t5_pre_we_b", 32'(bus.mem_we_b), 32'd0);
        reset = 1;
        #1;
        chk("t5_ce_b", 32'(bus.mem_ce_b), 32'd1);
        chk("t5_we_b", 32'(bus.mem_we_b), 32'd1);
        chk("t5_busy", 32'(bus.busy),     32'd0);
        bus.p1_req = 0;
        @(posedge clk); #2;
        reset = 0;
        repeat (15) @(posedge clk);
        chk("t5_no_ack", 32'(p0_ack_cnt + p1_ack_cnt), 32'd0);
        xfer(0, 1, 16'h0010, 16'h0000, 0, rc, ac, rd);
        chk("t5_after_rdata",   32'(rd),      32'h0000BEEF);
        chk("t5_after_latency", 32'(ac - rc), 32'd5);

        // req withdrawn during ACCESS: one ack, no second access
        clear_counts();
        @(posedge clk); #2;
        bus.p0_req = 1; bus.p0_rnw = 1; bus.p0_addr = 16'h0003;
        @(posedge clk); #2;
        bus.p0_req = 0;
        repeat (TB_WS + 8) @(posedge clk);
        chk("t6_acks",  32'(p0_ack_cnt), 32'd1);
        chk("t6_ce_low", 32'(ce_low_cnt), 32'd4);

        // randomized traffic from both masters
        fork
            for (int i = 0; i < 40; i++) begin
                int g, r0, a1;
                logic [15:0] x;
                g = $urandom_range(0, 3);
                xfer(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
                     (g == 0) && (i < 39), r0, a1, x);
                repeat (g) @(posedge clk);
            end
            for (int j = 0; j < 40; j++) begin
                int g, r0, a1;
                logic [15:0] x;
                g = $urandom_range(0, 3);
                xfer(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
                     (g == 0) && (j < 39), r0, a1, x);
                repeat (g) @(posedge clk);
            end
        join
        repeat (4) @(posedge clk);
        for (int a = 0; a < 32; a++) chk("final_mem", 32'(mem[a]), 32'(shadow[a]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/opc5_mem_arbiter.md
Name: opc5_mem_arbiter

Overview:
Two-port arbiter sharing one 16-bit single-port memory between the OPC5 CPU (port 0) and a second bus master (port 1), e.g. a DMA engine or program loader. Each port uses a req/ack handshake. The arbiter sequences one memory access at a time with a programmable number of wait states and drives active-low chip-enable and write-enable strobes. It sits between the masters and the memory array in the system top level and in the testbench.

Parameters:
ADDR_W, 16, address width of both ports and of the memory side
DATA_W, 16, data width of both ports and of the memory side
WAIT_STATES, 0, extra ACCESS cycles per transfer (0..15); counter width is 4 bits

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
p0_req  input  1  port 0 (CPU) request; held high with p0_addr/p0_rnw/p0_wdata stable until p0_ack
p0_rnw  input  1  port 0 direction: 1 = read, 0 = write
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_ack  output  1  one-cycle completion pulse for port 0
p1_req, p1_rnw, p1_addr, p1_wdata, p1_ack  (same directions, widths and meaning for port 1)
rdata  output  DATA_W  read data, valid in the cycle ack is high; shared by both ports
busy  output  1  high whenever the FSM is not in IDLE
mem_addr  output  ADDR_W  registered memory address
mem_wdata  output  DATA_W  registered memory write data
mem_rdata  input  DATA_W  memory read data, combinational from mem_addr
mem_ce_b  output  1  active-low chip enable
mem_we_b  output  1  active-low write enable

Behaviour:
- All outputs are registered. While reset is high, the following hold immediately, without waiting for a clock edge: state=IDLE, p0_ack=p1_ack=0, rdata=0, busy=0, mem_addr=0, mem_wdata=0, mem_ce_b=1, mem_we_b=1, wait counter=0, last_grant=1 (so port 0 wins the first contention).
- States:
  - IDLE:
    - If any req is high, latch the winner into grant, load mem_addr/mem_wdata/rnw from the winning port, load counter=WAIT_STATES, and go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - mem_ce_b=0; mem_we_b=0 only for a write.
    - If counter≠0, decrement and stay.
    - If counter=0:
      - for a read, capture mem_rdata into rdata;
      - go to DONE.
  - DONE:
    - mem_ce_b=1, mem_we_b=1.
    - ack of the granted port = 1 for exactly this cycle; rdata is valid here.
    - Always return to IDLE; no back-to-back grant from DONE. This prevents re-granting a req that is still high.
  - The strobe registers are updated on the same edge as the state, so ce_b and we_b match the state exactly.
- Timing:
  - A req sampled in IDLE at edge k gives ACCESS for cycles k+1 .. k+1+WAIT_STATES.
  - The ack cycle is k+2+WAIT_STATES.
  - Peak throughput is one access per WAIT_STATES+3 cycles.
- Arbitration is round robin:
  - On simultaneous requests, the port other than last_grant wins.
  - last_grant is updated when the grant is made.
  - A lone requester always wins, regardless of last_grant.
- Address and write data stay stable through ACCESS and DONE, and then until the next grant. This guarantees address hold across the rising edge of we_b.
- The writeback (capture) for a write does not touch rdata; rdata keeps its previous value.
- If req drops during ACCESS (protocol violation), the access still completes and ack still pulses.
- The non-granted port's req is only observed in IDLE; it waits without loss.
- Reset asserted during ACCESS:
  - the strobes deassert immediately and the access is abandoned;
  - no ack is issued after reset releases;
  - memory content for an interrupted write is undefined.

Optional Feature:
OPC5_ARB_FIXED_PRIO_EN
- Defined: fixed priority, where port 0 (CPU) always wins simultaneous requests. last_grant is not implemented. Port 1 can starve while p0_req is continuously high.
- Undefined: round robin as described above.

Test Plan:
- Single read, WAIT_STATES=0, mem[0x0010]=0xBEEF: p0 reads 0x0010 -> mem_ce_b low for 1 cycle, p0_ack exactly 2 cycles after req sampled, rdata=0xBEEF, p1_ack stays 0.
- Single write, WAIT_STATES=3: p1 writes 0x1234 to 0x00FF -> mem_we_b low for exactly 4 cycles, then p1_ack; mem[0x00FF]=0x1234; rdata unchanged.
- Contention after reset, both ports request at the same edge (p0 reads 0x0001, p1 writes 0xA5A5 to 0x0002):
  - round robin build: p0 is served first, then p1; a second simultaneous pair gives p1 first;
  - with OPC5_ARB_FIXED_PRIO_EN: p0 is first both times.
- Back-to-back: p0 holds req across 4 reads of 0x0000..0x0003 with WAIT_STATES=0 -> acks exactly 3 cycles apart, busy low for exactly 1 cycle between accesses.
- Reset mid-write (WAIT_STATES=5), assert reset during the 3rd ACCESS cycle -> mem_ce_b=mem_we_b=1 and busy=0 immediately; no ack after release; the next request is serviced normally.
- req withdrawn during ACCESS -> ack still pulses once; no second access starts.
